combo_lock_param: RTL
=====================

# combo_lock_param

Parametrised, clocked combination lock for the keypad front end. It samples a one-hot-or-encoded key bus and treats a nonzero value following an all-zero value as one key press. The first CODE_LEN presses after clear are stored as the code. Later presses are checked against the stored code in order, and `unlock` asserts on a full match. It adds what the first-generation combinational lock lacked: synchronous operation, configurable digit width and code length, a failed-attempt counter with timed lockout, and status outputs for the display logic.

## Interface

Parameters:
- DIGIT_W, 4: key bus width. Value 0 means "no key"; every other value is a digit.
- CODE_LEN, 4: number of digits in the code, 1..15.
- MAX_FAIL, 3: failed attempts that trigger lockout, 1..15.
- LOCKOUT_CYCLES, 1024: lockout duration in clk cycles, ≥1.
- Local: IDX_W = $clog2(CODE_LEN+1); FAIL_W = $clog2(MAX_FAIL+1); LCK_W = $clog2(LOCKOUT_CYCLES+1).

Ports:
- clk, in, 1: the single clock; all state changes on its rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- key_in, in, DIGIT_W: key bus. Asynchronous to the lock; upstream double-syncs and debounces it.
- relock, in, 1: when in OPEN, discard the code and return to PROG.
- master_clear, in, 1: from any state, discard code and fail count and return to PROG.
- unlock, out, 1: high only in OPEN.
- armed, out, 1: high in ARMED (code stored, awaiting entry).
- lockout, out, 1: high in LOCKOUT.
- digit_idx, out, IDX_W: digits stored (PROG) or digits matched so far (ARMED); 0 otherwise.
- fail_cnt, out, FAIL_W: consecutive failed attempts.

## Operation

- Press detect: register `key_held`. A press occurs when `key_in != 0` and `key_held == 0`. `key_held` is set to `(key_in != 0)` every cycle. One press is counted per release/press cycle, so holding a key counts once.
- States: PROG, ARMED, OPEN, LOCKOUT.
- PROG:
  - Each press writes `key_in` to `code[digit_idx]` and increments `digit_idx`.
  - On the CODE_LEN-th press, go to ARMED with `digit_idx = 0`.
  - `relock` is ignored.
- ARMED:
  - A press equal to `code[digit_idx]` increments `digit_idx`. If this completes CODE_LEN matches, go to OPEN and clear `fail_cnt`.
  - A press that does not match clears `digit_idx` and increments `fail_cnt`, saturating at MAX_FAIL. The mismatched press is not re-evaluated as digit 0.
  - When `fail_cnt` reaches MAX_FAIL, go to LOCKOUT.
- OPEN:
  - `relock` clears the code and goes to PROG.
  - Any press returns to ARMED with the code kept and `digit_idx = 0`. The press is consumed.
- LOCKOUT:
  - Presses are ignored and the counter loads LOCKOUT_CYCLES on entry, then decrements.
  - At 0, go to ARMED with `fail_cnt = 0`.
- Priority in the same cycle: `rst_n` low, then `master_clear`, then `relock`, then press.
- A press in the same cycle as a winning `master_clear` or `relock` is dropped. `key_held` still updates.
- The stored code is cleared to all-zero whenever PROG is entered.

## Timing

- Reset (`rst_n` low at an edge):
  - State PROG; code, `digit_idx`, `fail_cnt` and the lockout counter are 0.
  - `unlock`, `armed` and `lockout` are 0.
  - `key_held` is 1, so a key held through reset release must be released before it counts.
- All outputs are registered and reflect state after the edge.
- Press to effect: 1 cycle. A press sampled at edge N changes state and outputs after edge N.
- `unlock` rises the cycle after the final matching press.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles. `lockout` is high for LOCKOUT_CYCLES cycles, and `armed` rises on the next cycle.
- Back-to-back presses need at least 1 cycle of `key_in == 0` between them.
- `master_clear` or `relock` held for multiple cycles has no additional effect beyond remaining in PROG.

## Configuration

- COMBO_LOCKOUT_EN, defined: LOCKOUT state, lockout counter and the `lockout` output behave as above.
- Undefined:
  - No LOCKOUT state and no counter is synthesised; `lockout` is tied 0.
  - `fail_cnt` still counts and saturates at MAX_FAIL.
  - Mismatches only clear `digit_idx`; the lock stays ARMED.

## Test plan

Bench parameters: DIGIT_W=4, CODE_LEN=4, MAX_FAIL=3, LOCKOUT_CYCLES=16, with COMBO_LOCKOUT_EN defined unless noted.

1. Program 3,7,1,9, each press separated by 0, then enter 3,7,1,9 -> `armed`=1 after the 4th program press; `unlock`=1 exactly 1 cycle after the final 9; `fail_cnt`=0.
2. With code 3,7,1,9, enter 3,7,2 -> `digit_idx` goes 1,2,0 and `fail_cnt`=1. Then enter 3,7,1,9 -> `unlock`=1 and `fail_cnt`=0.
3. Make three wrong presses (5,5,5) -> `lockout`=1 for 16 cycles with presses ignored; then `armed`=1 and `fail_cnt`=0. Repeat with COMBO_LOCKOUT_EN undefined -> `lockout` stays 0, `fail_cnt`=3, `armed` stays 1.
4. In OPEN, assert `relock` together with a press of 4 -> PROG, `digit_idx`=0, press dropped. Program 4,4,4,4 and enter it -> unlock.
5. Hold `key_in`=6 through `rst_n` release, then release and press 6 -> exactly one stored digit (`digit_idx`=1).
6. Assert `master_clear` in LOCKOUT and in OPEN -> PROG next cycle, all status outputs 0.

Source files
------------

// File: rtl/combo_lock_param.sv
// combo_lock_param: clocked keypad combination lock with programmable code and fail counter.
// Define COMBO_LOCKOUT_EN to add the timed LOCKOUT state after MAX_FAIL failed attempts.
module combo_lock_param #(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  localparam int IDX_W  = $clog2(CODE_LEN + 1),
  localparam int FAIL_W = $clog2(MAX_FAIL + 1),
  localparam int LCK_W  = $clog2(LOCKOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] key_in,
  input  logic               relock,
  input  logic               master_clear,
  output logic               unlock,
  output logic               armed,
  output logic               lockout,
  output logic [IDX_W-1:0]   digit_idx,
  output logic [FAIL_W-1:0]  fail_cnt
);
  typedef enum logic [1:0] {PROG, ARMED, OPEN, LOCKOUT} state_t;
  state_t state_q, state_d;
  logic [DIGIT_W-1:0] code_q [2**IDX_W];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic held_q, press, hit, last, wr, clr;
  assign press = (key_in != '0) && !held_q;
  assign hit = key_in == code_q[idx_q];
  assign last = idx_q == IDX_W'(CODE_LEN - 1);
`ifdef COMBO_LOCKOUT_EN
  logic [LCK_W-1:0] lck_q, lck_d;
  always_ff @(posedge clk) lck_q <= !rst_n ? '0 : lck_d;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    fail_d = fail_q;
    wr = 1'b0;
    clr = 1'b0;
`ifdef COMBO_LOCKOUT_EN
    lck_d = lck_q;
`endif
    if (master_clear) begin
      state_d = PROG;
      idx_d = '0;
      fail_d = '0;
      clr = 1'b1;
`ifdef COMBO_LOCKOUT_EN
      lck_d = '0;
`endif
    end else if (state_q == OPEN && relock) begin
      state_d = PROG;
      idx_d = '0;
      clr = 1'b1;
    end else begin
      case (state_q)
        PROG: if (press) begin
          wr = 1'b1;
          idx_d = last ? '0 : idx_q + 1'b1;
          state_d = last ? ARMED : PROG;
        end
        ARMED: if (press) begin
          if (hit) begin
            idx_d = last ? '0 : idx_q + 1'b1;
            state_d = last ? OPEN : ARMED;
            fail_d = last ? '0 : fail_q;
          end else begin
            idx_d = '0;
            fail_d = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;
`ifdef COMBO_LOCKOUT_EN
            state_d = (fail_d == FAIL_W'(MAX_FAIL)) ? LOCKOUT : ARMED;
            lck_d = LCK_W'(LOCKOUT_CYCLES);
`endif
          end
        end
        OPEN: if (press) begin
          state_d = ARMED;
          idx_d = '0;
        end
`ifdef COMBO_LOCKOUT_EN
        // leave on the edge that takes the counter to zero: LOCKOUT_CYCLES cycles exactly
        LOCKOUT: begin
          lck_d = lck_q - 1'b1;
          state_d = (lck_q == LCK_W'(1)) ? ARMED : LOCKOUT;
          fail_d = (lck_q == LCK_W'(1)) ? '0 : fail_q;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PROG;
      idx_q <= '0;
      fail_q <= '0;
      held_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      fail_q <= fail_d;
      held_q <= key_in != '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < 2**IDX_W; i++) code_q[i] <= '0;
    end else if (wr) begin
      code_q[idx_q] <= key_in;
    end
  end
  assign unlock = state_q == OPEN;
  assign armed = state_q == ARMED;
`ifdef COMBO_LOCKOUT_EN
  assign lockout = state_q == LOCKOUT;
`else
  assign lockout = 1'b0;
`endif
  assign digit_idx = (state_q == PROG || state_q == ARMED) ? idx_q : '0;
  assign fail_cnt = fail_q;
endmodule
